// File: rtl/fanout_eager_fork.sv
// Eager fork: broadcasts each upstream token to a masked set of consumers,
// each accepting independently; upstream is released once all have taken it.
module fanout_eager_fork #(
  parameter int DATA_W   = 17,
  parameter int NUM_DEST = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                flush,
  input  logic [NUM_DEST-1:0] cfg_dest_mask,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    tok_cnt
);

  logic                full_q, full_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_DEST-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                last_clear;
  logic                accept;
  logic                zero_mask;
  logic [NUM_DEST-1:0] hs;

  assign out_valid  = {NUM_DEST{full_q}} & pending_q;
  assign hs         = out_valid & out_ready & {NUM_DEST{clk_en}};
  assign last_clear = full_q &
                      ((pending_q & ~(out_ready & pending_q)) == '0);
  // rst_n gate keeps upstream stalled while reset is held
  assign in_ready   = rst_n & clk_en & ~flush & (~full_q | last_clear);
  assign accept     = in_valid & in_ready;
  assign zero_mask  = (cfg_dest_mask == '0);

  assign out_data = data_q;
  assign busy     = full_q;
  assign tok_cnt  = cnt_q;

  always_comb begin
    full_d    = full_q;
    data_d    = data_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    if (clk_en) begin
      if (flush) begin
        full_d    = 1'b0;
        pending_d = '0;
        cnt_d     = '0;
      end else begin
        pending_d = pending_q & ~hs;
        if (last_clear) begin
          full_d = 1'b0;
        end
        if (accept) begin
          data_d    = in_data;
          pending_d = cfg_dest_mask;
          full_d    = ~zero_mask;
        end
        cnt_d = cnt_q
              + CNT_W'(last_clear)
              + CNT_W'(accept & zero_mask);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= 1'b0;
      data_q    <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      full_q    <= full_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fanout_eager_fork.sv
// Randomized bench for fanout_eager_fork against a per-destination
// token-ownership reference model.
module tb_fanout_eager_fork;

  localparam int DW = 17;
  localparam int ND = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en;
  logic          flush;
  logic [ND-1:0] cfg_dest_mask;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [ND-1:0] out_valid;
  logic [ND-1:0] out_ready;
  logic          busy;
  logic [CW-1:0] tok_cnt;

  fanout_eager_fork #(
    .DATA_W(DW), .NUM_DEST(ND), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .cfg_dest_mask(cfg_dest_mask), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .tok_cnt(tok_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: who still owes an acceptance of the held token.
  bit            m_full;
  logic [DW-1:0] m_data;
  bit            m_owe[ND];
  int            m_cnt;

  task automatic model_reset();
    m_full = 0;
    m_data = '0;
    foreach (m_owe[i]) m_owe[i] = 0;
    m_cnt = 0;
  endtask

  function automatic bit exp_in_ready();
    bit all_take;
    all_take = 1;
    for (int i = 0; i < ND; i++)
      if (m_owe[i] && !out_ready[i]) all_take = 0;
    return clk_en && !flush && (!m_full || all_take);
  endfunction

  // Compare outputs with inputs settled, then advance model over the edge.
  task automatic step();
    logic [ND-1:0] ev;
    bit rdy, acc, left;
    #1;
    ev = '0;
    for (int i = 0; i < ND; i++) ev[i] = m_full && m_owe[i];
    rdy = exp_in_ready();
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("busy", 32'(busy), 32'(m_full));
    chk("tok_cnt", 32'(tok_cnt), 32'(m_cnt));
    if (m_full) chk("out_data", 32'(out_data), 32'(m_data));
    acc = in_valid && rdy;
    if (clk_en) begin
      if (flush) begin
        m_full = 0;
        foreach (m_owe[i]) m_owe[i] = 0;
        m_cnt = 0;
      end else begin
        if (m_full) begin
          left = 0;
          for (int i = 0; i < ND; i++) begin
            if (m_owe[i] && out_ready[i]) m_owe[i] = 0;
            if (m_owe[i]) left = 1;
          end
          if (!left) begin
            m_full = 0;
            m_cnt = (m_cnt + 1) % (1 << CW);
          end
        end
        if (acc) begin
          m_data = in_data;
          for (int i = 0; i < ND; i++) m_owe[i] = cfg_dest_mask[i];
          m_full = (cfg_dest_mask != '0);
          if (cfg_dest_mask == '0) m_cnt = (m_cnt + 1) % (1 << CW);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clk_en = 1'b1;
    flush = 1'b0;
    cfg_dest_mask = 4'hF;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = '0;
    model_reset();
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tok_cnt", 32'(tok_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back stream, all consumers ready
    out_ready = 4'hF;
    in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = DW'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("stream_cnt", 32'(tok_cnt), 32'd8);

    // zero mask tokens are dropped but counted
    cfg_dest_mask = '0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = DW'(16'h100 + k);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("zero_mask_cnt", 32'(tok_cnt), 32'd11);

    // staggered acceptance on mask 1011
    cfg_dest_mask = 4'b1011;
    out_ready = '0;
    in_data = DW'(16'h0AA);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 4'b0001; step();
    out_ready = 4'b0000; step();
    out_ready = 4'b0010; step();
    out_ready = 4'b0000; step();
    out_ready = 4'b1000; step();
    out_ready = 4'b0000; step();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      flush = clk_en && ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_data = DW'($urandom());
      out_ready = ND'($urandom());
      if ($urandom_range(0, 9) == 0)
        cfg_dest_mask = ($urandom_range(0, 6) == 0) ? '0 : ND'($urandom());
      if (c % 500 == 250 && m_full) begin
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_tok_cnt", 32'(tok_cnt), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fanout_eager_fork.md
Name: fanout_eager_fork

Overview:
- Producer-side end of the stream fanout handshake: takes one ready/valid input stream and broadcasts each token to a configurable subset of NUM_DEST consumers.
- Each consumer accepts independently, in any cycle. A per-destination pending mask records which consumers have not yet taken the current token.
- Upstream sees ready only once every selected destination has accepted, so a slow consumer never forces a fast one to wait in lockstep.
- Sits between a SAM primitive output (crd/ref/val stream) and multiple downstream primitives.

Parameters:
- DATA_W, 17, width of the stream token (16-bit payload plus control/done bit).
- NUM_DEST, 4, number of downstream consumers (1..8).
- CNT_W, 16, width of the debug token counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clk_en  input  1  global clock enable; when 0 all state holds and no handshake completes
- flush  input  1  synchronous clear of holding register, pending mask and counter
- cfg_dest_mask  input  NUM_DEST  static config: bit i=1 means destination i receives tokens
- in_data  input  DATA_W  upstream token
- in_valid  input  1  upstream valid
- in_ready  output  1  upstream ready
- out_data  output  DATA_W  broadcast token, common to all destinations
- out_valid  output  NUM_DEST  per-destination valid
- out_ready  input  NUM_DEST  per-destination ready
- busy  output  1  holding register occupied
- tok_cnt  output  CNT_W  number of tokens fully retired

Behaviour:
- Reset (rst_n=0, asynchronous): holding register empty, pending=0, out_data=0, out_valid=0, busy=0, tok_cnt=0.
  - in_ready=0 while reset is asserted; in_ready=1 from the first cycle after deassertion.
- State per cycle: full flag, data register, pending[NUM_DEST].
- out_valid[i] = full & pending[i]. out_data = data register, held stable while full.
- Destination handshake i completes when out_valid[i] & out_ready[i] & clk_en. pending[i] clears on the next edge.
- last_clear (combinational) = full & ((pending & ~(out_ready & pending)) == 0).
- in_ready = clk_en & ~flush & (~full | last_clear).
  - This is a combinational path out_ready -> in_ready; it is required so the block sustains one token per cycle.
- Upstream accept: in_valid & in_ready. On accept:
  - data register <= in_data.
  - pending <= cfg_dest_mask.
  - full <= (cfg_dest_mask != 0).
- Zero mask: a token accepted with cfg_dest_mask==0 is consumed and dropped. full stays 0 and tok_cnt increments.
- Retire: when last_clear and there is no simultaneous accept, full <= 0. tok_cnt increments once per retired token.
- Simultaneous retire and accept: the new token loads in the same edge, the old token is counted, and there is no bubble.
- Latency: in_data to out_valid is 1 cycle. No combinational in->out data path.
- tok_cnt wraps modulo 2^CNT_W.
- flush=1: full<=0, pending<=0, tok_cnt<=0. No accept occurs that cycle. Flush takes priority over every handshake.
- clk_en=0: no state change; out_valid remains visible, but no handshake counts.
- cfg_dest_mask changes mid-token: they do not affect the current pending mask; they take effect on the next accepted token.
- Reset asserted mid-token: the token is discarded.

Test Plan:
- NUM_DEST=4, mask=4'b1111, all out_ready=1, tokens 0x001..0x008 streamed back-to-back -> out_valid=4'hF each cycle after first, in_ready held 1, tok_cnt=8, 1-cycle latency.
- mask=4'b1011, token 0x0AA, out_ready[0]=1 at cycle 1, [1] at cycle 3, [3] at cycle 5 -> out_valid goes 1011,1010,1010,1000,1000,0000; in_ready=1 only at cycle 5; dest 2 never valid.
- Holding full, remaining pending=4'b0100, out_ready[2]=1 and in_valid=1 with 0x155 same cycle -> in_ready=1, next cycle out_data=0x155, out_valid=mask, tok_cnt+1.
- mask=0, 3 tokens offered -> all accepted consecutively, out_valid stays 0, tok_cnt=3.
- Token pending on 2 destinations, flush=1 for one cycle -> out_valid=0, busy=0, tok_cnt=0 next cycle; in_ready low during flush.
- clk_en=0 for 3 cycles with all out_ready=1 -> pending unchanged, in_ready=0; rst_n pulse mid-token -> all outputs zero immediately (asynchronous).
